// File: rtl/ureg_pkg.sv
// Shared definitions for the user-register bus arbiter: state encoding,
// default bus widths and the fixed requester slot assignments.
package ureg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WR   = 3'd2,
    ST_RDW  = 3'd3,
    ST_RDC  = 3'd4,
    ST_DONE = 3'd5
  } ureg_state_e;

  localparam int UREG_AW = 8;
  localparam int UREG_DW = 16;

  localparam int UREG_REQ_UART = 0;
  localparam int UREG_REQ_I2C  = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first valid requester found searching
// upward from last+1 (modulo NREQ) wins; any is set when at least one is valid.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] pick,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  // cand[n] is the requester examined at search distance n+1 from last
  logic [IW-1:0] cand [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = IW'((int'(last) + gi + 1) % NREQ);
    end
  endgenerate

  // Walk from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    pick = last;
    any  = 1'b0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (valid[cand[off]]) begin
        pick = cand[off];
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ureg_arbiter.sv
// Round-robin arbiter and single-transaction sequencer for the user-register
// bus; generates the one-cycle ureg_write / ureg_rack strobes and req_ack.
module ureg_arbiter
  import ureg_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = UREG_AW,
  parameter int DW      = UREG_DW,
  parameter int RD_WAIT = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_write,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*DW-1:0]      req_wdata,
  output logic [NREQ-1:0]         req_ack,
  output logic [DW-1:0]           rsp_rdata,
  output logic [AW-1:0]           ureg_addr,
  output logic [DW-1:0]           ureg_datain,
  output logic                    ureg_write,
  output logic                    ureg_rack,
  input  logic [DW-1:0]           ureg_dataout,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IW = $clog2(NREQ);
  // RDW is entered already holding its first cycle, so the counter loads RD_WAIT-1
  localparam logic [3:0] RD_LOAD = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

  ureg_state_e   state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [3:0]    wait_q, wait_d;

  logic [IW-1:0] pick;
  logic          any_valid;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .valid (req_valid),
    .last  (grant_q),
    .pick  (pick),
    .any   (any_valid)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          write_d = req_write[pick];
          addr_d  = req_addr[int'(pick)*AW +: AW];
          wdata_d = req_wdata[int'(pick)*DW +: DW];
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (write_q) begin
          state_d = ST_WR;
        end else if (RD_WAIT == 0) begin
          state_d = ST_RDC;
        end else begin
          wait_d  = RD_LOAD;
          state_d = ST_RDW;
        end
      end
      ST_WR: state_d = ST_DONE;
      ST_RDW: begin
        if (wait_q == 4'd0) begin
          state_d = ST_RDC;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_RDC: begin
        rdata_d = ureg_dataout;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= IW'(NREQ - 1);
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
    end
  end

  // Strobes decode straight from state, so an async reset kills them at once.
  always_comb begin
    req_ack = '0;
    if (state_q == ST_DONE) begin
      req_ack[grant_q] = 1'b1;
    end
  end

  assign ureg_write  = (state_q == ST_WR);
  assign ureg_rack   = (state_q == ST_RDC);
  assign busy        = (state_q != ST_IDLE);
  assign ureg_addr   = addr_q;
  assign ureg_datain = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_ureg_arbiter.sv
// Self-checking bench for ureg_arbiter: directed scenarios plus a randomized
// run checked against a round-robin / fixed-latency reference model.
module tb_ureg_arbiter;

  localparam int NREQ    = 2;
  localparam int AW      = 8;
  localparam int DW      = 16;
  localparam int RD_WAIT = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   req_ack;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     ureg_addr;
  logic [DW-1:0]     ureg_datain;
  logic              ureg_write;
  logic              ureg_rack;
  logic [DW-1:0]     ureg_dataout;
  logic              busy;
  logic [0:0]        grant_id;

  int total = 0;
  int bad = 0;
  int last_grant = NREQ - 1;

  ureg_arbiter #(
    .NREQ    (NREQ),
    .AW      (AW),
    .DW      (DW),
    .RD_WAIT (RD_WAIT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ack      (req_ack),
    .rsp_rdata    (rsp_rdata),
    .ureg_addr    (ureg_addr),
    .ureg_datain  (ureg_datain),
    .ureg_write   (ureg_write),
    .ureg_rack    (ureg_rack),
    .ureg_dataout (ureg_dataout),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first valid requester searching upward from last+1.
  function automatic int rr_model(input logic [NREQ-1:0] v, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      int i;
      i = (last + off) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    int ack_c;
    logic [NREQ-1:0] ack_v;
    reset_n = 1'b0;
    repeat (2) tick();
    total++;
    if ({req_ack, rsp_rdata, ureg_addr, ureg_datain, ureg_write, ureg_rack, busy} !== '0)
      begin bad++; $display("FAIL reset_outputs got=%h exp=0",
        {req_ack, rsp_rdata, ureg_addr, ureg_datain, ureg_write, ureg_rack, busy}); end
    total++;
    if (grant_id !== 1'(NREQ - 1))
      begin bad++; $display("FAIL reset_grant got=%0d exp=%0d", grant_id, NREQ - 1); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    req_write = 2'b01;
    req_addr[7:0] = 8'h55;
    req_wdata[15:0] = 16'h0a0a;
    req_valid = 2'b01;
    ack_c = -1;
    ack_v = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) req_valid = 2'b00;
      if (req_ack != 2'b00 && ack_c < 0) begin
        ack_c = c;
        ack_v = req_ack;
      end
    end
    total++;
    if (ack_c != 3) begin bad++; $display("FAIL reset_first_ack_cycle got=%0d exp=3", ack_c); end
    total++;
    if (ack_v !== 2'b01) begin bad++; $display("FAIL reset_first_ack_vec got=%b exp=01", ack_v); end
    last_grant = 0;
    $display("txn reset: first ack at cycle %0d vec=%b", ack_c, ack_v);
  endtask

  task automatic test_write_r1();
    int exp_w;
    req_write = 2'b10;
    req_addr[15:8] = 8'h3a;
    req_wdata[31:16] = 16'hbeef;
    req_valid = 2'b10;
    exp_w = rr_model(req_valid, last_grant);
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++;
      if (ureg_addr !== 8'h3a) begin bad++; $display("FAIL wr_addr c=%0d got=%h exp=3a", c, ureg_addr); end
      total++;
      if (ureg_datain !== 16'hbeef) begin bad++; $display("FAIL wr_data c=%0d got=%h exp=beef", c, ureg_datain); end
      total++;
      if (ureg_write !== (c == 2)) begin bad++; $display("FAIL wr_strobe c=%0d got=%b exp=%b", c, ureg_write, c == 2); end
      total++;
      if (ureg_rack !== 1'b0) begin bad++; $display("FAIL wr_rack c=%0d got=%b exp=0", c, ureg_rack); end
      total++;
      if (req_ack !== ((c == 3) ? 2'b10 : 2'b00)) begin bad++; $display("FAIL wr_ack c=%0d got=%b", c, req_ack); end
      total++;
      if (int'(grant_id) != exp_w) begin bad++; $display("FAIL wr_grant c=%0d got=%0d exp=%0d", c, grant_id, exp_w); end
    end
    req_valid = 2'b00;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wr_idle got=%b exp=0", busy); end
    last_grant = exp_w;
    $display("txn write r1: addr=%h data=%h", ureg_addr, ureg_datain);
  endtask

  task automatic test_read_r0();
    req_write = 2'b00;
    req_addr[7:0] = 8'h10;
    ureg_dataout = 16'h1234;
    req_valid = 2'b01;
    for (int c = 1; c <= 5; c++) begin
      tick();
      total++;
      if (ureg_addr !== 8'h10) begin bad++; $display("FAIL rd_addr c=%0d got=%h exp=10", c, ureg_addr); end
      total++;
      if (ureg_write !== 1'b0) begin bad++; $display("FAIL rd_write c=%0d got=%b exp=0", c, ureg_write); end
      total++;
      if (ureg_rack !== (c == 4)) begin bad++; $display("FAIL rd_rack c=%0d got=%b exp=%b", c, ureg_rack, c == 4); end
      total++;
      if (req_ack !== ((c == 5) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL rd_ack c=%0d got=%b", c, req_ack); end
      if (c == 5) begin
        total++;
        if (rsp_rdata !== 16'h1234) begin bad++; $display("FAIL rd_data got=%h exp=1234", rsp_rdata); end
      end
    end
    req_valid = 2'b00;
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rd_idle got=%b exp=0", busy); end
    last_grant = 0;
    $display("txn read r0: rdata=%h", rsp_rdata);
  endtask

  task automatic test_reset_mid_read();
    req_write = 2'b00;
    req_addr[7:0] = 8'h77;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++;
    if (grant_id !== 1'(NREQ - 1)) begin bad++; $display("FAIL midrst_grant got=%0d exp=%0d", grant_id, NREQ - 1); end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (ureg_rack !== 1'b0 || req_ack !== 2'b00)
        begin bad++; $display("FAIL midrst_strobe c=%0d rack=%b ack=%b exp=0", c, ureg_rack, req_ack); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || grant_id !== 1'(NREQ - 1))
      begin bad++; $display("FAIL midrst_after busy=%b grant=%0d exp=0/%0d", busy, grant_id, NREQ - 1); end
    last_grant = NREQ - 1;
    $display("txn reset mid-read: busy=%b grant=%0d", busy, grant_id);
  endtask

  task automatic test_contention();
    int exp_w;
    logic was_busy;
    logic [NREQ-1:0] exp_ack;
    req_write = 2'b10;
    req_addr = {8'h41, 8'h40};
    req_wdata = {16'h4141, 16'h4040};
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_w = rr_model(req_valid, last_grant);
      exp_ack = NREQ'(1) << exp_w;
      was_busy = busy;
      for (int c = 0; c <= 10; c++) begin
        if (c == 10) begin bad++; total++; $display("FAIL cont_grant_timeout t=%0d got=busy%b exp=grant", t, busy); end
        else begin
          tick();
          if (busy && !was_busy) break;
          was_busy = busy;
        end
      end
      total++;
      if (int'(grant_id) != exp_w) begin bad++; $display("FAIL cont_grant t=%0d got=%0d exp=%0d", t, grant_id, exp_w); end
      for (int c = 0; c <= 10; c++) begin
        total++;
        if (ureg_write && ureg_rack) begin bad++; $display("FAIL cont_overlap t=%0d got=11 exp=not both", t); end
        if (req_ack != 2'b00) break;
        if (c == 10) begin bad++; total++; $display("FAIL cont_ack_timeout t=%0d got=none exp=%b", t, exp_ack); end
        else tick();
      end
      total++;
      if (req_ack !== exp_ack) begin bad++; $display("FAIL cont_ack t=%0d got=%b exp=%b", t, req_ack, exp_ack); end
      last_grant = exp_w;
      $display("txn contention %0d: grant=%0d ack=%b", t, grant_id, req_ack);
    end
    req_valid = 2'b00;
    repeat (2) tick();
  endtask

  task automatic test_change_after_grant();
    req_write = 2'b01;
    req_addr[7:0] = 8'h20;
    req_wdata[15:0] = 16'hcafe;
    req_valid = 2'b01;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) begin
        req_addr[7:0] = 8'h21;
        req_valid = 2'b00;
      end
      total++;
      if (ureg_addr !== 8'h20) begin bad++; $display("FAIL chg_addr c=%0d got=%h exp=20", c, ureg_addr); end
      total++;
      if (req_ack !== ((c == 3) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL chg_ack c=%0d got=%b", c, req_ack); end
    end
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL chg_idle got=%b exp=0", busy); end
    last_grant = 0;
    $display("txn change-after-grant: addr=%h", ureg_addr);
  endtask

  task automatic test_random();
    int exp_w, lat, rack_c;
    logic exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rd;
    logic [NREQ-1:0] v, exp_ack;
    for (int t = 0; t < 30; t++) begin
      v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_write = NREQ'($urandom);
      req_addr = (NREQ*AW)'($urandom);
      req_wdata = (NREQ*DW)'($urandom);
      exp_w = rr_model(v, last_grant);
      exp_wr = req_write[exp_w];
      exp_addr = req_addr[exp_w*AW +: AW];
      exp_wdata = req_wdata[exp_w*DW +: DW];
      exp_ack = NREQ'(1) << exp_w;
      lat = exp_wr ? 3 : 3 + RD_WAIT;
      rack_c = 2 + RD_WAIT;
      exp_rd = 'x;
      req_valid = v;
      ureg_dataout = DW'($urandom);
      for (int c = 1; c <= lat; c++) begin
        tick();
        total++;
        if (int'(grant_id) != exp_w || ureg_addr !== exp_addr || ureg_datain !== exp_wdata)
          begin bad++; $display("FAIL rnd_bus t=%0d c=%0d got=%0d/%h/%h exp=%0d/%h/%h", t, c,
            grant_id, ureg_addr, ureg_datain, exp_w, exp_addr, exp_wdata); end
        total++;
        if (ureg_write !== (exp_wr && c == 2) || ureg_rack !== (!exp_wr && c == rack_c))
          begin bad++; $display("FAIL rnd_strobe t=%0d c=%0d got=%b%b", t, c, ureg_write, ureg_rack); end
        total++;
        if (req_ack !== ((c == lat) ? exp_ack : 2'b00))
          begin bad++; $display("FAIL rnd_ack t=%0d c=%0d got=%b exp=%b", t, c, req_ack, exp_ack); end
        if (!exp_wr && c == lat) begin
          total++;
          if (rsp_rdata !== exp_rd) begin bad++; $display("FAIL rnd_rdata t=%0d got=%h exp=%h", t, rsp_rdata, exp_rd); end
        end
        req_write = NREQ'($urandom);
        req_addr = (NREQ*AW)'($urandom);
        req_wdata = (NREQ*DW)'($urandom);
        ureg_dataout = DW'($urandom);
        if (c == rack_c) exp_rd = ureg_dataout;
      end
      req_valid = '0;
      last_grant = exp_w;
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rnd_idle t=%0d got=%b exp=0", t, busy); end
      $display("txn random %0d: req=%0d %s addr=%h", t, exp_w, exp_wr ? "wr" : "rd", exp_addr);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    ureg_dataout = '0;
    test_reset();
    test_write_r1();
    test_read_r0();
    test_reset_mid_read();
    test_contention();
    test_change_after_grant();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ureg_arbiter.md
# ureg_arbiter

Round-robin arbiter and sequencer for the shared user-register bus (`ureg_*`). It lets several requesters issue single 16-bit register reads and writes without colliding on the bus: the UART command interpreter, the I2C poll sequencer, and future masters. It sits between those masters and the register file / FIFO block. It generates the one-cycle `ureg_write` and `ureg_rack` strobes that the register side already expects.

## Interface
Parameters:
- `NREQ`, 2: number of requesters; index 0 is the UART command path.
- `AW`, 8: register address width.
- `DW`, 16: register data width.
- `RD_WAIT`, 2: settle cycles between driving a read address and sampling `ureg_dataout`; legal range 0–15.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_write` in NREQ: 1 = write, 0 = read.
- `req_addr` in NREQ*AW: packed addresses; requester i uses `[i*AW +: AW]`.
- `req_wdata` in NREQ*DW: packed write data.
- `req_ack` out NREQ: one-cycle completion pulse to the granted requester.
- `rsp_rdata` out DW: read data; valid in the `req_ack` cycle and held until the next read capture.
- `ureg_addr` out AW: register bus address.
- `ureg_datain` out DW: register bus write data.
- `ureg_write` out 1: one-cycle write strobe.
- `ureg_rack` out 1: one-cycle read-acknowledge strobe, used to pop FIFOs.
- `ureg_dataout` in DW: register bus read data.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out $clog2(NREQ): index of the current or last granted requester.

## Operation
- FSM states: IDLE, ADDR, WR, RDW, RDC, DONE.
- **IDLE**
  - If any `req_valid` is set, pick the winner by round robin, starting at `grant_id+1` and wrapping modulo NREQ.
  - Latch the winner's write/addr/wdata into the bus registers.
  - Update `grant_id` and go to ADDR.
- **ADDR**: `ureg_addr` and `ureg_datain` are stable. Go to WR if the request is a write; otherwise go to RDW.
- **WR**: `ureg_write`=1 for exactly this cycle, then go to DONE.
- **RDW**: count `RD_WAIT` cycles, then go to RDC. With `RD_WAIT`=0, pass through RDW for zero cycles (ADDR goes straight to RDC).
- **RDC**: capture `ureg_dataout` into `rsp_rdata` and assert `ureg_rack`=1 for this cycle. Go to DONE.
- **DONE**: `req_ack[grant_id]`=1 for this cycle, then return to IDLE.
- Request fields are sampled only at grant. Changes to `req_*` after grant are ignored, and the ack is issued even if `req_valid` dropped.
- A requester holds `req_valid` until it sees `req_ack`, and deasserts it in the cycle after the ack if it has nothing further. A still-high valid in the IDLE cycle after DONE is treated as a new request.
- Only one transaction is in flight. No pipelining, no aborts.
- Reset values: every output is 0, FSM is IDLE, `grant_id`=NREQ-1 so that requester 0 has first priority after reset.
- Reset asserted mid-transaction returns to IDLE immediately and suppresses any pending strobe or ack. The interrupted requester must reissue.

## Timing
- Take the cycle in which IDLE sees `req_valid` as cycle k.
  - ADDR is cycle k+1.
  - Write: `ureg_write` in cycle k+2, `req_ack` in cycle k+3.
  - Read: `ureg_rack` in cycle k+2+RD_WAIT, `req_ack` in cycle k+3+RD_WAIT.
- Minimum spacing between grants:
  - Write: 4 cycles.
  - Read: 4+RD_WAIT cycles.
- `ureg_addr` and `ureg_datain` stay stable from ADDR through DONE, and hold their values in IDLE (no return to zero).
- `ureg_write` and `ureg_rack` are never high together and never high for more than one cycle.
- If requesters i and j are valid in the same IDLE cycle, the first of them found searching upward from `grant_id+1` wins. The loser is served on the next grant if it stays valid. Worst-case wait is NREQ-1 transactions.

## Structure
- Shared package `ureg_pkg` holds:
  - the state encoding enum;
  - defaults `UREG_AW`=8 and `UREG_DW`=16;
  - the index constants `UREG_REQ_UART`=0 and `UREG_REQ_I2C`=1.
- One sub-module, `rr_pick`: a combinational round-robin priority picker. Inputs are the valid vector and the last grant; outputs are the winner index and an any-valid flag.
- The FSM, the RD_WAIT counter and the bus registers live in `ureg_arbiter`.

## Test plan
- **Reset**: all outputs 0 and `busy`=0. With `req_valid`=2'b01 pulsed just after `reset_n` rises, `req_ack`=2'b01 arrives 3 cycles after grant.
- **Write from requester 1**: addr=8'h3a, wdata=16'hbeef → `ureg_addr`=3a and `ureg_datain`=beef from k+1, `ureg_write` in cycle k+2 only, `req_ack`=2'b10 in cycle k+3.
- **Read with RD_WAIT=2**: requester 0, addr=8'h10, `ureg_dataout`=16'h1234 → `ureg_rack` in cycle k+4, `rsp_rdata`=1234 with `req_ack`=2'b01 in cycle k+5.
- **Contention**: both requesters valid continuously for 4 transactions → grants alternate 0,1,0,1; no strobe overlap.
- **Reset mid-read**: assert `reset_n`=0 during RDW → no `ureg_rack` and no `req_ack`; after release, state is IDLE and `grant_id` is NREQ-1.
- **Request change after grant**: requester 0 changes addr from 8'h20 to 8'h21 and drops valid in cycle k+1 → bus still uses 8'h20 and `req_ack[0]` still pulses.
